mem_access_unit: RTL

Parametrised memory-port sequencer for the multi-cycle CPU generation. It arbitrates among NUM_CH internal requesters, for example instruction fetch and data load/store. It drives the single external memory handshake (readM/writeM, address, bidirectional data, inputReady/ackOutput) and returns one completion per accepted request. A per-transaction timeout detects a non-responding memory. This replaces direct wiring of the PC/ALU result onto the memory port.

---
 rtl/mem_access_unit_if.sv | 27 ++
 rtl/mem_access_unit.sv | 120 ++++++++++++
 2 files changed

// File: rtl/mem_access_unit_if.sv
// Requester-side handshake bundle for mem_access_unit: per-channel request
// lanes in, one-hot completion pulses and shared response data out.
interface mem_access_unit_if #(
    parameter int WORD_W = 16,
    parameter int ADDR_W = 16,
    parameter int NUM_CH = 2
);
    logic [NUM_CH-1:0]        req_valid;
    logic [NUM_CH-1:0]        req_we;
    logic [NUM_CH*ADDR_W-1:0] req_addr;
    logic [NUM_CH*WORD_W-1:0] req_wdata;
    logic [NUM_CH-1:0]        req_ready;
    logic [NUM_CH-1:0]        resp_valid;
    logic                     resp_err;
    logic [WORD_W-1:0]        resp_rdata;

    // Requesters (fetch, load/store) drive requests and observe completions.
    modport master (
        output req_valid, req_we, req_addr, req_wdata,
        input  req_ready, resp_valid, resp_err, resp_rdata
    );

    modport slave (
        input  req_valid, req_we, req_addr, req_wdata,
        output req_ready, resp_valid, resp_err, resp_rdata
    );
endinterface

// File: rtl/mem_access_unit.sv
// Memory-port sequencer: fixed-priority arbitration over NUM_CH requesters,
// one outstanding readM/writeM transaction with timeout, one completion each.
module mem_access_unit #(
    parameter int WORD_W  = 16,
    parameter int ADDR_W  = 16,
    parameter int NUM_CH  = 2,
    parameter int TIMEOUT = 255,
    parameter int CNT_W   = 8
) (
    input  logic              clk,
    input  logic              reset_n,
    mem_access_unit_if.slave  req_if,
    output logic              readM,
    output logic              writeM,
    output logic [ADDR_W-1:0] address,
    inout  wire  [WORD_W-1:0] data,
    input  logic              inputReady,
    input  logic              ackOutput
);
    localparam int CH_W = (NUM_CH > 1) ? $clog2(NUM_CH) : 1;

    typedef enum logic [1:0] {IDLE, ACCESS, DONE} state_t;

    state_t            state_q, state_d;
    logic [CH_W-1:0]   ch_q, grant_idx;
    logic [NUM_CH-1:0] grant_oh;
    logic              grant_any;
    logic              we_q, err_q;
    logic [ADDR_W-1:0] addr_q;
    logic [WORD_W-1:0] wdata_q, rdata_q;
    logic [CNT_W-1:0]  cnt_q, cnt_inc;
    logic              complete, timeout_hit;

    // NOTE: every always_comb output gets a default first, so no path can infer a latch.
    always_comb begin
        grant_idx = '0;
        grant_oh  = '0;
        grant_any = |req_if.req_valid;
        // Walk downwards so the lowest-index requester wins.
        for (int i = NUM_CH - 1; i >= 0; i--) begin
            if (req_if.req_valid[i]) grant_idx = CH_W'(i);
        end
        if (grant_any) grant_oh[grant_idx] = 1'b1;
    end

    // Ready depends only on valid, state and reset, never on itself.
    assign req_if.req_ready = (reset_n && state_q == IDLE) ? grant_oh : '0;

    assign cnt_inc     = cnt_q + CNT_W'(1);
    assign complete    = (state_q == ACCESS) && (we_q ? ackOutput : inputReady);
    assign timeout_hit = (TIMEOUT != 0) && (cnt_inc == CNT_W'(TIMEOUT));

    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE:    if (grant_any) state_d = ACCESS;
            ACCESS:  if (complete || timeout_hit) state_d = DONE;
            DONE:    state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    // NOTE: sequential state uses non-blocking assignments only, so every flop samples pre-edge values.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) state_q <= IDLE;
        else          state_q <= state_d;
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            ch_q    <= '0;
            we_q    <= 1'b0;
            addr_q  <= '0;
            wdata_q <= '0;
            rdata_q <= '0;
            err_q   <= 1'b0;
            cnt_q   <= '0;
        end else begin
            case (state_q)
                IDLE: begin
                    if (grant_any) begin
                        ch_q    <= grant_idx;
                        we_q    <= req_if.req_we[grant_idx];
                        addr_q  <= req_if.req_addr[grant_idx*ADDR_W +: ADDR_W];
                        wdata_q <= req_if.req_wdata[grant_idx*WORD_W +: WORD_W];
                        cnt_q   <= '0;
                    end
                end
                ACCESS: begin
                    cnt_q <= cnt_inc;
                    // Completion takes precedence over a timeout on the same edge.
                    if (complete) begin
                        err_q   <= 1'b0;
                        rdata_q <= we_q ? '0 : data;
                    end else if (timeout_hit) begin
                        err_q   <= 1'b1;
                        rdata_q <= '0;
                    end
                end
                default: ;
            endcase
        end
    end

    assign readM   = (state_q == ACCESS) && !we_q;
    assign writeM  = (state_q == ACCESS) &&  we_q;
    assign address = addr_q;
    assign data    = writeM ? wdata_q : {WORD_W{1'bz}};

    always_comb begin
        req_if.resp_valid = '0;
        req_if.resp_err   = 1'b0;
        req_if.resp_rdata = '0;
        if (state_q == DONE) begin
            req_if.resp_valid[ch_q] = 1'b1;
            req_if.resp_err         = err_q;
            req_if.resp_rdata       = rdata_q;
        end
    end
endmodule
